// File: rtl/cog_hub_port.sv
// ---------------------------------------------------------------------------
// cog_hub_port
//   Per-cog hub access port in front of the hub arbiter. Turns a single hub
//   instruction request, or a COGINIT load request, into the hub bus request
//   signals. The request is held until this cog's bus acknowledge arrives.
//   A load runs a LOAD_LEN-long burst of hub long reads into cog RAM.
//
// Ports
//   clk_cog, nres          cog clock, asynchronous active-low reset
//   ena                    cog enabled; low aborts to IDLE on the next edge
//   ena_bus, ack           hub strobe and this cog's ack; ack counts only
//                          when ena_bus is high
//   bus_q, bus_c           shared hub result data and carry
//   req, req_s/w/a/d       single hub op request (accepted in IDLE)
//   load, load_ptr         load burst request (accepted in IDLE, wins over req)
//   bus_r/e/w/s/a/d        hub bus request outputs (registered)
//   busy                   state != IDLE (decoded from the state register)
//   done, q, c             single-op completion pulse and captured result
//   ram_w, ram_a, ram_d    cog RAM write port driven by the load burst
//   load_done              one-cycle pulse when the burst completes
// ---------------------------------------------------------------------------
module cog_hub_port #(
    parameter int LOAD_LEN = 496
) (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        ena,
    input  logic        ena_bus,
    input  logic        ack,
    input  logic [31:0] bus_q,
    input  logic        bus_c,
    input  logic        req,
    input  logic [1:0]  req_s,
    input  logic        req_w,
    input  logic [15:0] req_a,
    input  logic [31:0] req_d,
    input  logic        load,
    input  logic [13:0] load_ptr,
    output logic        bus_r,
    output logic        bus_e,
    output logic        bus_w,
    output logic [1:0]  bus_s,
    output logic [15:0] bus_a,
    output logic [31:0] bus_d,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic        c,
    output logic        ram_w,
    output logic [8:0]  ram_a,
    output logic [31:0] ram_d,
    output logic        load_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        LOAD   = 2'd2
    } state_t;

    // Hub request as presented to the arbiter.
    typedef struct packed {
        logic        r;
        logic        e;
        logic        w;
        logic [1:0]  s;
        logic [15:0] a;
        logic [31:0] d;
    } hub_req_t;

    localparam logic [8:0] LAST_CNT = 9'(LOAD_LEN - 1);
    localparam logic [1:0] SZ_LONG  = 2'b10;

    state_t     state_q, state_d;
    hub_req_t   hreq_q;
    logic [8:0] count_q;
    logic [13:0] addr_q;
    logic [13:0] addr_nxt;
    logic       ack_cyc;
    logic       last_ack;

    assign ack_cyc  = ena_bus & ack;
    assign last_ack = ack_cyc && (count_q == LAST_CNT);
    assign addr_nxt = addr_q + 14'd1;   // wraps modulo 2^14 by width

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load)     state_d = LOAD;
                    else if (req) state_d = SINGLE;
                end
                SINGLE: begin
                    if (ack_cyc) state_d = IDLE;
                end
                LOAD: begin
                    if (last_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // Registered datapath and outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            hreq_q    <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            done      <= 1'b0;
            q         <= '0;
            c         <= 1'b0;
            ram_w     <= 1'b0;
            ram_a     <= '0;
            ram_d     <= '0;
            load_done <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            done      <= 1'b0;
            ram_w     <= 1'b0;
            load_done <= 1'b0;

            if (!ena) begin
                // Abort: drop the request, no completion side effects.
                hreq_q.e <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (load) begin
                            // Loader access: r=0 tells the hub to unscramble ROM.
                            hreq_q.r <= 1'b0;
                            hreq_q.e <= 1'b1;
                            hreq_q.w <= 1'b0;
                            hreq_q.s <= SZ_LONG;
                            hreq_q.a <= {load_ptr, 2'b00};
                            addr_q   <= load_ptr;
                            count_q  <= '0;
                        end else if (req) begin
                            hreq_q.r <= 1'b1;
                            hreq_q.e <= 1'b1;
                            hreq_q.w <= req_w;
                            hreq_q.s <= req_s;
                            hreq_q.a <= req_a;
                            hreq_q.d <= req_d;
                        end
                    end
                    SINGLE: begin
                        if (ack_cyc) begin
                            q        <= bus_q;
                            c        <= bus_c;
                            hreq_q.e <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (ack_cyc) begin
                            ram_w    <= 1'b1;
                            ram_a    <= count_q;
                            ram_d    <= bus_q;
                            count_q  <= count_q + 9'd1;
                            addr_q   <= addr_nxt;
                            hreq_q.a <= {addr_nxt, 2'b00};
                            if (last_ack) begin
                                hreq_q.e  <= 1'b0;
                                load_done <= 1'b1;
                            end
                        end
                    end
                    default: hreq_q.e <= 1'b0;
                endcase
            end
        end
    end

    assign bus_r = hreq_q.r;
    assign bus_e = hreq_q.e;
    assign bus_w = hreq_q.w;
    assign bus_s = hreq_q.s;
    assign bus_a = hreq_q.a;
    assign bus_d = hreq_q.d;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cog_hub_port.sv
// ---------------------------------------------------------------------------
// tb_cog_hub_port
//   Directed bench for cog_hub_port. Inputs change and outputs are sampled
//   on the falling edge of clk_cog; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_cog_hub_port;

    localparam int LOAD_LEN = 496;

    logic        clk_cog = 1'b0;
    logic        nres = 1'b0;
    logic        ena = 1'b1;
    logic        ena_bus = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] bus_q = '0;
    logic        bus_c = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  req_s = '0;
    logic        req_w = 1'b0;
    logic [15:0] req_a = '0;
    logic [31:0] req_d = '0;
    logic        load = 1'b0;
    logic [13:0] load_ptr = '0;
    logic        bus_r, bus_e, bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;
    logic        busy, done;
    logic [31:0] q;
    logic        c;
    logic        ram_w;
    logic [8:0]  ram_a;
    logic [31:0] ram_d;
    logic        load_done;

    int checks = 0;
    int errors = 0;

    cog_hub_port #(.LOAD_LEN(LOAD_LEN)) dut (
        .clk_cog(clk_cog), .nres(nres), .ena(ena), .ena_bus(ena_bus), .ack(ack),
        .bus_q(bus_q), .bus_c(bus_c), .req(req), .req_s(req_s), .req_w(req_w),
        .req_a(req_a), .req_d(req_d), .load(load), .load_ptr(load_ptr),
        .bus_r(bus_r), .bus_e(bus_e), .bus_w(bus_w), .bus_s(bus_s), .bus_a(bus_a),
        .bus_d(bus_d), .busy(busy), .done(done), .q(q), .c(c), .ram_w(ram_w),
        .ram_a(ram_a), .ram_d(ram_d), .load_done(load_done)
    );

    always #5 clk_cog = ~clk_cog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_cog);
    endtask

    initial begin
        int          k;
        int          nram;
        int          nld;
        logic        prev_w;
        logic        eb;
        logic [13:0] ea;

        // ---------------- reset ----------------
        tick;
        chk("rst_all", 32'(|{bus_r, bus_e, bus_w, bus_s, bus_a, bus_d, busy, done,
                             q, c, ram_w, ram_a, ram_d, load_done}), 0);
        nres = 1'b1;
        tick;
        chk("rst_rel_busy", busy, 0);
        chk("rst_rel_bus_e", bus_e, 0);

        // ---------------- rdlong $1234 ----------------
        req = 1'b1; req_s = 2'b10; req_w = 1'b0; req_a = 16'h1234; req_d = '0;
        tick;
        req = 1'b0;
        chk("rd_issue_e", bus_e, 1);
        chk("rd_issue_busy", busy, 1);
        chk("rd_issue_r", bus_r, 1);
        chk("rd_issue_s", bus_s, 2'b10);
        for (int i = 0; i < 12; i++) begin
            ena_bus = (i % 2 == 0); ack = 1'b0;
            tick;
            chk("rd_hold_e", bus_e, 1);
            chk("rd_hold_a", bus_a, 16'h1234);
            chk("rd_hold_done", done, 0);
        end
        ena_bus = 1'b1; ack = 1'b1; bus_q = 32'hDEADBEEF;
        tick;
        chk("rd_done", done, 1);
        chk("rd_q", q, 32'hDEADBEEF);
        chk("rd_busy_end", busy, 0);
        chk("rd_e_end", bus_e, 0);
        ack = 1'b0; ena_bus = 1'b0;
        tick;
        chk("rd_done_pulse", done, 0);
        chk("rd_q_hold", q, 32'hDEADBEEF);

        // ---------------- wrbyte ----------------
        req = 1'b1; req_s = 2'b00; req_w = 1'b1; req_a = 16'h0101; req_d = 32'h000000A5;
        tick;
        req = 1'b0;
        chk("wb_w", bus_w, 1);
        chk("wb_d", bus_d, 32'hA5);
        chk("wb_r", bus_r, 1);
        chk("wb_s", bus_s, 0);
        chk("wb_a", bus_a, 16'h0101);
        ena_bus = 1'b0; ack = 1'b1; bus_q = 32'h11;
        tick;
        chk("wb_noack_done", done, 0);
        chk("wb_noack_e", bus_e, 1);
        chk("wb_noack_w", bus_w, 1);
        tick;
        chk("wb_noack_busy", busy, 1);
        chk("wb_noack_r", bus_r, 1);
        ena_bus = 1'b1; ack = 1'b1;
        tick;
        chk("wb_done", done, 1);
        chk("wb_q", q, 32'h11);
        chk("wb_e_end", bus_e, 0);

        // ---------------- back-to-back sys lockset ----------------
        req = 1'b1; req_s = 2'b11; req_w = 1'b0; req_a = 16'd6; req_d = '0;
        ack = 1'b0; ena_bus = 1'b0;
        tick;
        req = 1'b0;
        chk("sys_b2b_e", bus_e, 1);
        chk("sys_s", bus_s, 2'b11);
        chk("sys_a", bus_a, 16'd6);
        chk("sys_done_low", done, 0);
        ena_bus = 1'b1; ack = 1'b1; bus_q = 32'd3; bus_c = 1'b1;
        tick;
        chk("sys_done", done, 1);
        chk("sys_c", c, 1);
        chk("sys_q", q, 3);
        ack = 1'b0; ena_bus = 1'b0;

        // ---------------- abort a single op ----------------
        req = 1'b1; req_s = 2'b10; req_w = 1'b0; req_a = 16'h0008;
        tick;
        req = 1'b0;
        chk("ab1_e", bus_e, 1);
        ena = 1'b0; ena_bus = 1'b1; ack = 1'b1; bus_q = 32'hFFFFFFFF; bus_c = 1'b0;
        tick;
        chk("ab1_busy", busy, 0);
        chk("ab1_e_off", bus_e, 0);
        chk("ab1_done", done, 0);
        chk("ab1_q_keep", q, 3);
        chk("ab1_c_keep", c, 1);
        ena = 1'b1; ack = 1'b0; ena_bus = 1'b0;
        tick;

        // ---------------- load wins over req; full burst, 1-in-2 strobe ----------------
        load = 1'b1; req = 1'b1; req_s = 2'b00; req_a = 16'h0000; load_ptr = 14'h3FFE;
        tick;
        load = 1'b0; req = 1'b0;
        chk("ld_busy", busy, 1);
        chk("ld_e", bus_e, 1);
        chk("ld_r", bus_r, 0);
        chk("ld_w", bus_w, 0);
        chk("ld_s", bus_s, 2'b10);
        chk("ld_a0", bus_a, 16'hFFF8);
        k = 0; nram = 0; nld = 0; prev_w = 1'b0; eb = 1'b0;
        for (int cyc = 0; cyc < 2000 && busy; cyc++) begin
            eb = ~eb;
            ena_bus = eb; ack = 1'b1; bus_q = 32'(k);
            tick;
            if (ram_w) nram++;
            if (load_done) nld++;
            chk("ld_ram_w_adj", 32'(prev_w & ram_w), 0);
            prev_w = ram_w;
            if (eb) begin
                ea = 14'h3FFE + 14'(k + 1);
                chk("ld_ram_w", ram_w, 1);
                chk("ld_ram_a", ram_a, 32'(k));
                chk("ld_ram_d", ram_d, 32'(k));
                chk("ld_bus_a", bus_a, {16'h0, ea, 2'b00});
                chk("ld_bus_e", bus_e, 32'(k != LOAD_LEN - 1));
                chk("ld_bus_r", bus_r, 0);
                chk("ld_done_pulse", load_done, 32'(k == LOAD_LEN - 1));
                k++;
            end else begin
                chk("ld_ram_w_idle", ram_w, 0);
            end
        end
        chk("ld_end_busy", busy, 0);
        chk("ld_nram", 32'(nram), 32'(LOAD_LEN));
        chk("ld_nld", 32'(nld), 1);
        ack = 1'b0; ena_bus = 1'b0;
        tick;
        chk("ld_ram_a_hold", ram_a, 32'(LOAD_LEN - 1));
        chk("ld_ram_d_hold", ram_d, 32'(LOAD_LEN - 1));
        chk("ld_done_clear", load_done, 0);

        // ---------------- abort a load at count=100 ----------------
        load = 1'b1; load_ptr = 14'h0010;
        tick;
        load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ena_bus = 1'b1; ack = 1'b1; bus_q = 32'h100 + 32'(i);
            tick;
        end
        chk("ab2_ram_a", ram_a, 99);
        chk("ab2_bus_a", bus_a, {16'h0, 14'h0010 + 14'd100, 2'b00});
        ena = 1'b0;
        tick;
        chk("ab2_busy", busy, 0);
        chk("ab2_e", bus_e, 0);
        chk("ab2_ld_done", load_done, 0);
        chk("ab2_ram_w", ram_w, 0);
        chk("ab2_ram_a_hold", ram_a, 99);
        chk("ab2_ram_d_hold", ram_d, 32'h100 + 32'd99);
        ena = 1'b1; ack = 1'b0; ena_bus = 1'b0;
        tick;
        chk("ab2_idle", busy, 0);
        chk("ab2_ld_done2", load_done, 0);

        // ---------------- async reset mid-load ----------------
        load = 1'b1; load_ptr = 14'h0005;
        tick;
        load = 1'b0; ena_bus = 1'b1; ack = 1'b1; bus_q = 32'h7;
        tick;
        tick;
        chk("rm_pre_busy", busy, 1);
        #2 nres = 1'b0;
        #1;
        chk("rm_all", 32'(|{bus_r, bus_e, bus_w, bus_s, bus_a, bus_d, busy, done,
                            q, c, ram_w, ram_a, ram_d, load_done}), 0);
        chk("rm_e", bus_e, 0);
        ack = 1'b0; ena_bus = 1'b0;
        tick;
        nres = 1'b1;
        tick;
        chk("rm_rel_busy", busy, 0);
        chk("rm_rel_e", bus_e, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
